// File: rtl/fifo_burst_drain.sv
// Burst read controller for the cache request FIFO; FIFO word reaches out_valid 1 cycle after its pop.
// Pops stall while the 2-entry output buffer is full. DRAIN_STATS_EN adds burst/timeout counters.
module fifo_burst_drain #(
  parameter int DATA_BIT_SIZE = 8,
  parameter int BURST_LEN     = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fifo_empty,
  input  logic                     fifo_A_empty,
  output logic                     fifo_read_en,
  input  logic [DATA_BIT_SIZE-1:0] fifo_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BIT_SIZE-1:0] out_data,
  output logic                     out_sop,
  output logic                     busy
`ifdef DRAIN_STATS_EN
  ,
  output logic [15:0]              stat_bursts,
  output logic [15:0]              stat_timeouts
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(BURST_LEN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ISSUED_MAX = IW'(BURST_LEN);

  logic [1:0]               state, state_nxt;
  logic [TW-1:0]            timer, timer_nxt;
  logic [IW-1:0]            issued, issued_nxt;
  logic [1:0]               occ;
  logic [DATA_BIT_SIZE-1:0] head_dat, tail_dat;
  logic                     head_sop, tail_sop;
  logic                     deq;
  logic                     push_sop;
  logic                     burst_done;
  logic                     timeout_hit;

  assign fifo_read_en = (state == DRAIN) && !fifo_empty && (occ != 2'd2) && (issued < ISSUED_MAX);
  assign out_valid    = (occ != 2'd0);
  assign out_data     = head_dat;
  assign out_sop      = head_sop;
  assign deq          = out_valid && out_ready;
  assign busy         = (state != IDLE) || (occ != 2'd0);
  assign push_sop     = (issued == '0);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    issued_nxt  = issued;
    burst_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = fifo_A_empty ? WAIT : DRAIN;
          timer_nxt = '0;
        end
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        if (fifo_empty) begin
          state_nxt = IDLE;
        end else if (!fifo_A_empty) begin
          state_nxt = DRAIN;
        end else if (timer == TIMER_LAST) begin
          state_nxt   = DRAIN;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_read_en) begin
          issued_nxt = issued + 1'b1;
        end
        // An empty FIFO never pops, so issued_nxt here is the final burst size.
        if ((fifo_read_en && (issued_nxt == ISSUED_MAX)) || fifo_empty) begin
          burst_done = (issued_nxt != '0);
          state_nxt  = IDLE;
          issued_nxt = '0;
          timer_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      timer  <= '0;
      issued <= '0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      issued <= issued_nxt;
    end
  end

  // Head entry is always the oldest word; a push during a dequeue at occ==1 replaces the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ      <= '0;
      head_dat <= '0;
      head_sop <= 1'b0;
      tail_dat <= '0;
      tail_sop <= 1'b0;
    end else begin
      case ({fifo_read_en, deq})
        2'b10: begin
          if (occ == 2'd0) begin
            head_dat <= fifo_read_data;
            head_sop <= push_sop;
          end else begin
            tail_dat <= fifo_read_data;
            tail_sop <= push_sop;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_dat <= tail_dat;
          head_sop <= tail_sop;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          head_dat <= fifo_read_data;
          head_sop <= push_sop;
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

`ifdef DRAIN_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_bursts   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (burst_done && (stat_bursts != 16'hFFFF)) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
      if (timeout_hit && (stat_timeouts != 16'hFFFF)) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`endif

endmodule
